branch_pc_sequencer: RTL and testbench

- Program-counter sequencer that consumes the resolve result of the IV32IBranch unit (do_branch) plus jump information from execute, and produces the next fetch address.
- Sits between execute and the shared instruction/data memory port of the Von Neumann core.
- Drives a single-outstanding fetch request/ack handshake, issues one instruction at a time and waits for its resolution.
- Detects misaligned control-flow targets and traps to a fixed vector.

---
 rtl/rv32i_pkg.sv | 15 +
 rtl/pc_target_calc.sv | 30 +++
 rtl/branch_pc_sequencer.sv | 102 ++++++++++
 tb/tb_branch_pc_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared definitions for the branch/PC sequencer: FSM state encoding,
// instruction size and trap cause codes.
package rv32i_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_ISSUE = 2'd1,
    ST_EXEC  = 2'd2,
    ST_TRAP  = 2'd3
  } state_t;

  localparam logic [31:0] INSTR_BYTES      = 32'd4;
  localparam logic [3:0]  MISALIGNED_FETCH = 4'd0;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC selection for the in-flight instruction, plus the
// alignment check on that target and the link address for JAL/JALR.
module pc_target_calc
  import rv32i_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        res_taken,
  input  logic        res_jump,
  input  logic        res_jalr,
  input  logic [31:0] res_imm,
  input  logic [31:0] res_rs1,
  output logic [31:0] target,
  output logic        misaligned,
  output logic [31:0] link_addr
);

  // Jumps outrank the branch-taken flag; JALR clears only bit 0.
  always_comb begin
    target = pc + INSTR_BYTES;
    if (res_jump && res_jalr) begin
      target = (res_rs1 + res_imm) & ~32'h1;
    end else if (res_jump || res_taken) begin
      target = pc + res_imm;
    end
  end

  assign misaligned = (target[1:0] != 2'b00);
  assign link_addr  = pc + INSTR_BYTES;

endmodule

// File: rtl/branch_pc_sequencer.sv
// Single-outstanding fetch sequencer: fetches one instruction, issues it,
// waits for its resolution and either moves to the target PC or traps.
module branch_pc_sequencer
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic        fetch_ack,
  output logic        instr_issue,
  output logic [31:0] pc,
  input  logic        res_valid,
  input  logic        res_taken,
  input  logic        res_jump,
  input  logic        res_jalr,
  input  logic [31:0] res_imm,
  input  logic [31:0] res_rs1,
  output logic [31:0] link_addr,
  output logic        trap,
  output logic [31:0] trap_epc,
  output logic [31:0] trap_tval,
  input  logic        trap_clear,
  output logic [31:0] retire_count
);

  state_t      state;
  logic [31:0] target;
  logic        misaligned;

  pc_target_calc u_target_calc (
    .pc         (pc),
    .res_taken  (res_taken),
    .res_jump   (res_jump),
    .res_jalr   (res_jalr),
    .res_imm    (res_imm),
    .res_rs1    (res_rs1),
    .target     (target),
    .misaligned (misaligned),
    .link_addr  (link_addr)
  );

  assign fetch_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_FETCH;
      pc           <= RESET_PC;
      fetch_req    <= 1'b0;
      instr_issue  <= 1'b0;
      trap         <= 1'b0;
      trap_epc     <= 32'h0;
      trap_tval    <= 32'h0;
      retire_count <= 32'h0;
    end else begin
      instr_issue <= 1'b0;
      case (state)
        // An ack seen before the request is raised belongs to no request.
        ST_FETCH: begin
          if (!fetch_req) begin
            fetch_req <= 1'b1;
          end else if (fetch_ack) begin
            fetch_req   <= 1'b0;
            instr_issue <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (res_valid) begin
            if (misaligned) begin
              trap      <= 1'b1;
              trap_epc  <= pc;
              trap_tval <= target;
              state     <= ST_TRAP;
            end else begin
              pc           <= target;
              retire_count <= retire_count + 32'd1;
              fetch_req    <= 1'b1;
              state        <= ST_FETCH;
            end
          end
        end
        ST_TRAP: begin
          if (trap_clear) begin
            trap      <= 1'b0;
            pc        <= TRAP_VECTOR;
            fetch_req <= 1'b1;
            state     <= ST_FETCH;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Bench for branch_pc_sequencer: directed control-flow scenarios followed by
// random instruction streams checked against a transaction-level PC model.
module tb_branch_pc_sequencer;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_ack = 1'b0;
  logic        res_valid = 1'b0;
  logic        res_taken = 1'b0;
  logic        res_jump = 1'b0;
  logic        res_jalr = 1'b0;
  logic [31:0] res_imm = 32'h0;
  logic [31:0] res_rs1 = 32'h0;
  logic        trap_clear = 1'b0;
  logic        fetch_req, instr_issue, trap;
  logic [31:0] fetch_addr, pc, link_addr, trap_epc, trap_tval, retire_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc  = RESET_PC;
  logic [31:0] m_ret = 32'h0;

  branch_pc_sequencer #(.RESET_PC(RESET_PC), .TRAP_VECTOR(TRAP_VECTOR)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_ack    (fetch_ack),
    .instr_issue  (instr_issue),
    .pc           (pc),
    .res_valid    (res_valid),
    .res_taken    (res_taken),
    .res_jump     (res_jump),
    .res_jalr     (res_jalr),
    .res_imm      (res_imm),
    .res_rs1      (res_rs1),
    .link_addr    (link_addr),
    .trap         (trap),
    .trap_epc     (trap_epc),
    .trap_tval    (trap_tval),
    .trap_clear   (trap_clear),
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_target(input logic [31:0] cur_pc, input logic taken,
                                             input logic jump, input logic jalr,
                                             input logic [31:0] imm, input logic [31:0] rs1);
    if (jump && jalr) return (rs1 + imm) & 32'hFFFF_FFFE;
    if (jump)         return cur_pc + imm;
    if (taken)        return cur_pc + imm;
    return cur_pc + 32'd4;
  endfunction

  // One full instruction: fetch with ack_dly wait cycles, issue, resolve.
  task automatic do_instr(input logic taken, input logic jump, input logic jalr,
                          input logic [31:0] imm, input logic [31:0] rs1, input int ack_dly);
    logic [31:0] exp_t;
    checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== m_pc) begin
      errors++;
      $display("FAIL fetch_start req=%0b addr=%h expected req=1 addr=%h", fetch_req, fetch_addr, m_pc);
    end
    for (int i = 0; i < ack_dly; i++) begin
      @(posedge clk); #1;
      checks++;
      if (fetch_req !== 1'b1 || fetch_addr !== m_pc || instr_issue !== 1'b0) begin
        errors++;
        $display("FAIL fetch_hold req=%0b addr=%h issue=%0b expected 1 %h 0", fetch_req, fetch_addr, instr_issue, m_pc);
      end
    end
    fetch_ack = 1'b1;
    @(posedge clk); #1;
    fetch_ack = 1'($urandom_range(0, 1));
    res_valid = 1'b1; res_jump = 1'b1; res_imm = 32'h3;
    checks++;
    if (instr_issue !== 1'b1 || fetch_req !== 1'b0) begin
      errors++;
      $display("FAIL issue_pulse issue=%0b req=%0b expected 1 0", instr_issue, fetch_req);
    end
    @(posedge clk); #1;
    res_valid = 1'b0; trap_clear = 1'b1; fetch_ack = 1'b1;
    checks++;
    if (instr_issue !== 1'b0 || fetch_req !== 1'b0 || pc !== m_pc || link_addr !== m_pc + 32'd4 || trap !== 1'b0) begin
      errors++;
      $display("FAIL exec_entry issue=%0b req=%0b pc=%h link=%h trap=%0b expected 0 0 %h %h 0",
               instr_issue, fetch_req, pc, link_addr, trap, m_pc, m_pc + 32'd4);
    end
    @(posedge clk); #1;
    trap_clear = 1'b0; fetch_ack = 1'b0;
    checks++;
    if (fetch_req !== 1'b0 || pc !== m_pc || trap !== 1'b0 || retire_count !== m_ret) begin
      errors++;
      $display("FAIL exec_wait req=%0b pc=%h trap=%0b ret=%0d expected 0 %h 0 %0d", fetch_req, pc, trap, retire_count, m_pc, m_ret);
    end
    res_valid = 1'b1; res_taken = taken; res_jump = jump; res_jalr = jalr; res_imm = imm; res_rs1 = rs1;
    @(posedge clk); #1;
    res_valid = 1'b0;
    exp_t = ref_target(m_pc, taken, jump, jalr, imm, rs1);
    if (exp_t[1:0] != 2'b00) begin
      checks++;
      if (trap !== 1'b1 || trap_epc !== m_pc || trap_tval !== exp_t || fetch_req !== 1'b0 ||
          pc !== m_pc || retire_count !== m_ret) begin
        errors++;
        $display("FAIL trap_entry trap=%0b epc=%h tval=%h req=%0b pc=%h ret=%0d expected 1 %h %h 0 %h %0d",
                 trap, trap_epc, trap_tval, fetch_req, pc, retire_count, m_pc, exp_t, m_pc, m_ret);
      end
      res_valid = 1'b1; fetch_ack = 1'b1; res_jump = 1'b0; res_taken = 1'b0;
      @(posedge clk); #1;
      res_valid = 1'b0; fetch_ack = 1'b0;
      checks++;
      if (trap !== 1'b1 || fetch_req !== 1'b0 || pc !== m_pc || retire_count !== m_ret) begin
        errors++;
        $display("FAIL trap_hold trap=%0b req=%0b pc=%h ret=%0d expected 1 0 %h %0d", trap, fetch_req, pc, retire_count, m_pc, m_ret);
      end
      trap_clear = 1'b1;
      @(posedge clk); #1;
      trap_clear = 1'b0;
      m_pc = TRAP_VECTOR;
      checks++;
      if (trap !== 1'b0 || fetch_req !== 1'b1 || fetch_addr !== m_pc || retire_count !== m_ret) begin
        errors++;
        $display("FAIL trap_clear trap=%0b req=%0b addr=%h ret=%0d expected 0 1 %h %0d", trap, fetch_req, fetch_addr, retire_count, m_pc, m_ret);
      end
    end else begin
      m_pc  = exp_t;
      m_ret = m_ret + 32'd1;
      checks++;
      if (pc !== m_pc || fetch_addr !== m_pc || fetch_req !== 1'b1 || retire_count !== m_ret || trap !== 1'b0) begin
        errors++;
        $display("FAIL retire pc=%h addr=%h req=%0b ret=%0d trap=%0b expected %h %h 1 %0d 0",
                 pc, fetch_addr, fetch_req, retire_count, trap, m_pc, m_pc, m_ret);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (fetch_req !== 1'b0 || instr_issue !== 1'b0 || trap !== 1'b0 || pc !== RESET_PC ||
        trap_epc !== 32'h0 || trap_tval !== 32'h0 || retire_count !== 32'h0) begin
      errors++;
      $display("FAIL reset_state req=%0b issue=%0b trap=%0b pc=%h epc=%h tval=%h ret=%0d expected all zero",
               fetch_req, instr_issue, trap, pc, trap_epc, trap_tval, retire_count);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (fetch_req !== 1'b0) begin
      errors++;
      $display("FAIL req_before_edge req=%0b expected 0", fetch_req);
    end
    @(posedge clk); #1;
    m_pc = RESET_PC; m_ret = 32'h0;
  endtask

  task automatic test_directed();
    do_instr(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0, 2);   // sequential 0 -> 4
    do_instr(1'b0, 1'b1, 1'b0, 32'h0000_003C, 32'h0, 0);   // jal to 0x40
    do_instr(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h0, 1);   // taken back to 0x30
    do_instr(1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 0);   // jump wins, 0x38
    do_instr(1'b0, 1'b1, 1'b1, 32'h0000_0007, 32'h1001, 0);// jalr 0x1008
    do_instr(1'b0, 1'b1, 1'b0, 32'hFFFF_F0F8, 32'h0, 0);   // back to 0x100
    do_instr(1'b0, 1'b1, 1'b0, 32'h0000_0006, 32'h0, 0);   // misaligned jal
    do_instr(1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h102, 0); // jalr bit1 traps
    do_instr(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    do_instr(1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0, 0);   // wrap to 0
    do_instr(1'b0, 1'b0, 1'b1, 32'h0000_0006, 32'h3, 0);   // jalr without jump ignored
  endtask

  task automatic test_random();
    logic [31:0] imm;
    for (int n = 0; n < 60; n++) begin
      imm = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 4) == 0) imm = imm | 32'($urandom_range(1, 3));
      do_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               imm, $urandom, int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_mid();
    #3;
    reset = 1'b1; fetch_ack = 1'b1;
    #1;
    checks++;
    if (fetch_req !== 1'b0 || pc !== RESET_PC || retire_count !== 32'h0 || trap !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_fetch req=%0b pc=%h ret=%0d trap=%0b expected 0 %h 0 0", fetch_req, pc, retire_count, trap, RESET_PC);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (fetch_req !== 1'b1 || instr_issue !== 1'b0 || fetch_addr !== RESET_PC) begin
      errors++;
      $display("FAIL ack_in_reset req=%0b issue=%0b addr=%h expected 1 0 %h", fetch_req, instr_issue, fetch_addr, RESET_PC);
    end
    fetch_ack = 1'b0;
    m_pc = RESET_PC; m_ret = 32'h0;
    do_instr(1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 1);
    fetch_ack = 1'b1;
    @(posedge clk); #1;
    fetch_ack = 1'b0;
    @(posedge clk); #1;
    res_valid = 1'b1; res_jump = 1'b0; res_taken = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (fetch_req !== 1'b0 || pc !== RESET_PC || instr_issue !== 1'b0 || retire_count !== 32'h0) begin
      errors++;
      $display("FAIL async_reset_exec req=%0b pc=%h issue=%0b ret=%0d expected 0 %h 0 0", fetch_req, pc, instr_issue, retire_count, RESET_PC);
    end
    res_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== RESET_PC) begin
      errors++;
      $display("FAIL restart_after_reset req=%0b addr=%h expected 1 %h", fetch_req, fetch_addr, RESET_PC);
    end
    m_pc = RESET_PC; m_ret = 32'h0;
    do_instr(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
